// File: rtl/multicycle_ctrl.sv
// Control FSM for the RV64I multicycle datapath: fetch, decode, execute, memory, writeback.
// Define ILLEGAL_TRAP_EN to send illegal opcodes to ERROR; otherwise they execute as a NOP.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic       alu_src_b,
    output logic       reg_write,
    output logic [1:0] wb_src,
    output logic       error,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_ERROR  = 4'd8
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Last counter value before the timeout fires; only meaningful when MEM_TIMEOUT != 0.
    localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [TMR_W-1:0] r_wait;
    logic             r_error;

    logic       w_isLoad;
    logic       w_isStore;
    logic       w_isExec;
    logic       w_isJump;
    logic       w_waiting;
    logic       w_timeout;
    logic [1:0] w_aluA;
    logic       w_aluB;

    assign w_isLoad  = (opcode == OP_LOAD);
    assign w_isStore = (opcode == OP_STORE);
    assign w_isExec  = (opcode == OP_R) || (opcode == OP_IMM) || w_isLoad || w_isStore
                    || (opcode == OP_AUIPC) || (opcode == OP_LUI);
    assign w_isJump  = (opcode == OP_JAL) || (opcode == OP_JALR);

    assign w_aluA = (opcode == OP_AUIPC) ? 2'b01 : (opcode == OP_LUI) ? 2'b10 : 2'b00;
    assign w_aluB = (opcode != OP_R);

    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && (r_wait == TO_LAST);

    // The wait counter restarts whenever the state is not stalled on memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_waiting ? (r_wait + TMR_W'(1)) : '0;
            if (w_next == S_ERROR) begin
                r_error <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_src   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        alu_src_a = 2'b00;
        alu_src_b = 1'b0;
        reg_write = 1'b0;
        wb_src    = 2'b00;

        unique case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_ERROR;
                end
            end
            S_DECODE: begin
                if (w_isExec) begin
                    w_next = S_EXEC;
                end else if (opcode == OP_BR) begin
                    w_next = S_BRANCH;
                end else if (w_isJump) begin
                    w_next = S_JUMP;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_ERROR;
`else
                    w_next = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                alu_src_a = w_aluA;
                alu_src_b = w_aluB;
                w_next    = (w_isLoad || w_isStore) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_src   = 1'b1;
                mem_we    = w_isStore;
                alu_src_a = w_aluA;
                alu_src_b = w_aluB;
                if (mem_ready) begin
                    w_next = w_isStore ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    w_next = S_ERROR;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_src    = w_isLoad ? 2'b01 : 2'b00;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b01;
                alu_src_b = 1'b1;
                pc_write  = branch_taken;
                pc_src    = branch_taken;
                w_next    = S_FETCH;
            end
            S_JUMP: begin
                reg_write = 1'b1;
                wb_src    = 2'b10;
                pc_write  = 1'b1;
                pc_src    = 1'b1;
                alu_src_b = 1'b1;
                alu_src_a = (opcode == OP_JAL) ? 2'b01 : 2'b00;
                w_next    = S_FETCH;
            end
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_IDLE;
        endcase
    end

    assign error   = r_error;
    assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instructions expand into per-cycle expectations
// from a transaction-level model, and one compare process checks them every cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_src, ir_write, pc_write, pc_src;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic       reg_write;
    logic [1:0] wb_src;
    logic       error;
    logic [3:0] state_o;

    typedef struct packed {
        logic [3:0] st;
        logic       req;
        logic       we;
        logic       src;
        logic       irw;
        logic       pcw;
        logic       pcs;
        logic [1:0] a;
        logic       b;
        logic       rw;
        logic [1:0] wb;
        logic       err;
    } outs_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    outs_t expQ[$];
    int    stateLog[$];
    int    checkCount = 0;
    int    passCount  = 0;
    int    cycleNo    = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .TMR_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_src(mem_src),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .wb_src(wb_src), .error(error), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Instruction classes and the per-phase output rules they imply.
    function automatic logic isExecClass(input logic [6:0] op);
        return op == OP_R || op == OP_IMM || op == OP_LOAD || op == OP_STORE
            || op == OP_AUIPC || op == OP_LUI;
    endfunction

    function automatic logic [1:0] aluA(input logic [6:0] op);
        if (op == OP_AUIPC) return 2'b01;
        if (op == OP_LUI)   return 2'b10;
        return 2'b00;
    endfunction

    function automatic outs_t idleExp();
        outs_t o = '0;
        return o;
    endfunction

    function automatic outs_t fetchExp(input logic rdy);
        outs_t o = '0;
        o.st = 4'd1; o.req = 1'b1; o.irw = rdy; o.pcw = rdy;
        return o;
    endfunction

    function automatic outs_t decodeExp();
        outs_t o = '0;
        o.st = 4'd2;
        return o;
    endfunction

    function automatic outs_t execExp(input logic [6:0] op);
        outs_t o = '0;
        o.st = 4'd3; o.a = aluA(op); o.b = (op != OP_R);
        return o;
    endfunction

    function automatic outs_t memExp(input logic [6:0] op);
        outs_t o = '0;
        o.st = 4'd4; o.req = 1'b1; o.src = 1'b1; o.we = (op == OP_STORE);
        o.a = aluA(op); o.b = (op != OP_R);
        return o;
    endfunction

    function automatic outs_t wbExp(input logic [6:0] op);
        outs_t o = '0;
        o.st = 4'd5; o.rw = 1'b1; o.wb = (op == OP_LOAD) ? 2'b01 : 2'b00;
        return o;
    endfunction

    function automatic outs_t branchExp(input logic tk);
        outs_t o = '0;
        o.st = 4'd6; o.a = 2'b01; o.b = 1'b1; o.pcw = tk; o.pcs = tk;
        return o;
    endfunction

    function automatic outs_t jumpExp(input logic [6:0] op);
        outs_t o = '0;
        o.st = 4'd7; o.rw = 1'b1; o.wb = 2'b10; o.pcw = 1'b1; o.pcs = 1'b1; o.b = 1'b1;
        o.a = (op == OP_JAL) ? 2'b01 : 2'b00;
        return o;
    endfunction

    function automatic outs_t errExp();
        outs_t o = '0;
        o.st = 4'd8; o.err = 1'b1;
        return o;
    endfunction

    task automatic applyStimulus(input logic rst, input logic rdy, input logic tk,
                                 input logic [6:0] op, input outs_t exp);
        @(posedge clk);
        #1;
        reset        = rst;
        mem_ready    = rdy;
        branch_taken = tk;
        opcode       = op;
        expQ.push_back(exp);
    endtask

    task automatic checkOutput(input outs_t exp);
        outs_t act;
        act.st = state_o;  act.req = mem_req;  act.we = mem_we;    act.src = mem_src;
        act.irw = ir_write; act.pcw = pc_write; act.pcs = pc_src;  act.a = alu_src_a;
        act.b = alu_src_b; act.rw = reg_write; act.wb = wb_src;    act.err = error;
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL cycle%0d outputs: got st=%0d vec=%h, expected st=%0d vec=%h",
                      cycleNo, act.st, act, exp.st, exp);
    endtask

    task automatic checkLit(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    always @(negedge clk) begin : compare
        outs_t e;
        cycleNo++;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            stateLog.push_back(int'(state_o));
            checkOutput(e);
        end
    end

    // Expand one instruction starting in FETCH into its cycle-by-cycle behaviour.
    task automatic runInstr(input logic [6:0] op, input int fw, input int mw, input logic tk);
        for (int i = 0; i < fw; i++) applyStimulus(1'b0, 1'b0, 1'b0, op, fetchExp(1'b0));
        applyStimulus(1'b0, 1'b1, 1'b0, op, fetchExp(1'b1));
        applyStimulus(1'b0, 1'b0, tk, op, decodeExp());
        if (isExecClass(op)) begin
            applyStimulus(1'b0, 1'b0, 1'b0, op, execExp(op));
            if (op == OP_LOAD || op == OP_STORE) begin
                for (int i = 0; i < mw; i++) applyStimulus(1'b0, 1'b0, 1'b0, op, memExp(op));
                applyStimulus(1'b0, 1'b1, 1'b0, op, memExp(op));
            end
            if (op != OP_STORE) applyStimulus(1'b0, 1'b0, 1'b0, op, wbExp(op));
        end else if (op == OP_BR) begin
            applyStimulus(1'b0, 1'b0, tk, op, branchExp(tk));
        end else if (op == OP_JAL || op == OP_JALR) begin
            applyStimulus(1'b0, 1'b0, 1'b0, op, jumpExp(op));
        end else begin
`ifdef ILLEGAL_TRAP_EN
            applyStimulus(1'b0, 1'b0, 1'b0, op, errExp());
            applyStimulus(1'b1, 1'b0, 1'b0, op, errExp());
            applyStimulus(1'b0, 1'b0, 1'b0, op, idleExp());
`endif
        end
    endtask

    initial begin
        int expSeq[6];
        expSeq = '{0, 1, 2, 3, 5, 1};
        reset = 1'b1; opcode = '0; branch_taken = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        stateLog.delete();

        applyStimulus(1'b0, 1'b0, 1'b0, OP_IMM, idleExp());
        runInstr(OP_IMM, 0, 0, 1'b0);
        runInstr(OP_LOAD, 0, 3, 1'b0);
        for (int i = 0; i < 6; i++) checkLit($sformatf("addiSeq%0d", i), stateLog[i], expSeq[i]);

        runInstr(OP_STORE, 3, 0, 1'b0);
        runInstr(OP_R, 0, 0, 1'b0);
        runInstr(OP_LUI, 0, 0, 1'b0);
        runInstr(OP_AUIPC, 1, 0, 1'b0);
        runInstr(OP_BR, 0, 0, 1'b1);
        runInstr(OP_BR, 0, 0, 1'b0);
        runInstr(OP_JAL, 0, 0, 1'b0);
        runInstr(OP_JALR, 0, 0, 1'b0);

        runInstr(OP_BAD, 0, 0, 1'b0);
`ifndef ILLEGAL_TRAP_EN
        applyStimulus(1'b0, 1'b0, 1'b0, OP_IMM, fetchExp(1'b0));
        @(negedge clk);
        checkLit("nopState", int'(state_o), 1);
        checkLit("nopError", int'(error), 0);
        runInstr(OP_IMM, 0, 0, 1'b0);
`endif

        // Reset in MEM with mem_ready high must win and block the writeback.
        applyStimulus(1'b0, 1'b1, 1'b0, OP_LOAD, fetchExp(1'b1));
        applyStimulus(1'b0, 1'b0, 1'b0, OP_LOAD, decodeExp());
        applyStimulus(1'b0, 1'b0, 1'b0, OP_LOAD, execExp(OP_LOAD));
        applyStimulus(1'b1, 1'b1, 1'b0, OP_LOAD, memExp(OP_LOAD));
        applyStimulus(1'b0, 1'b0, 1'b0, OP_LOAD, idleExp());

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, OP_IMM, fetchExp(1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, OP_IMM, errExp());
        applyStimulus(1'b0, 1'b1, 1'b0, OP_IMM, errExp());
        @(negedge clk);
        checkLit("toState", int'(state_o), 8);
        checkLit("toError", int'(error), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, OP_IMM, errExp());
        applyStimulus(1'b0, 1'b0, 1'b0, OP_IMM, idleExp());
        @(negedge clk);
        checkLit("rstError", int'(error), 0);
        runInstr(OP_IMM, 0, 0, 1'b0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy FSM that sequences the RV64I multicycle datapath: fetch, decode (regfile read plus immediateG), execute, memory, writeback.
- Drives all mux selects and write enables for PC, IR, ALU, memory and regfile from the IR opcode.
- Sits beside immediateG in the decode stage.
- PC is incremented during FETCH. Every PC-relative target is therefore computed as (PC+4) + offset-4, using the pre-adjusted immediate supplied by immediateG.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting for mem_ready in FETCH/MEM before ERROR; 0 disables the timeout.
- TMR_W, 8: width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0].
- branch_taken  in  1  result of the external branch comparator on rs1/rs2/funct3.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  store request.
- mem_src  out  1  address select: 0 = PC, 1 = ALU result.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0 = PC+4, 1 = ALU result (datapath clears bit 0 for jalr).
- alu_src_a  out  2  A operand: 00 = rs1, 01 = PC, 10 = zero.
- alu_src_b  out  1  B operand: 0 = rs2, 1 = immediate.
- reg_write  out  1  regfile write enable.
- wb_src  out  2  writeback source: 00 = ALU, 01 = memory data, 10 = PC.
- error  out  1  sticky fault flag.
- state_o  out  4  current state code.

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
- Reset: on any edge with reset=1, state goes to IDLE, the wait counter clears and error clears. This applies mid-operation and overrides a same-cycle mem_ready.
- Output defaults: every output not listed for a state is 0.
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BRANCH=6, JUMP=7, ERROR=8.
- IDLE: all outputs 0. Next state FETCH.
- FETCH: mem_req=1, mem_src=0.
  - Holds until mem_ready=1.
  - In the mem_ready cycle (Mealy): ir_write=1, pc_write=1, pc_src=0. Next state DECODE.
- DECODE: one cycle, no enables asserted. Next state by opcode:
  - 0110011, 0010011, 0000011, 0100011, 0010111, 0110111 -> EXEC.
  - 1100011 -> BRANCH.
  - 1101111, 1100111 -> JUMP.
  - any other opcode -> illegal (see Optional Feature).
- EXEC: one cycle.
  - alu_src_a = 01 for auipc, 10 for lui, 00 otherwise.
  - alu_src_b = 0 for R-type, 1 otherwise.
  - Next state MEM for load/store, WB otherwise.
- MEM: mem_req=1, mem_src=1, mem_we=1 for store only. ALU selects are held as in EXEC.
  - Holds until mem_ready.
  - On mem_ready: store -> FETCH, load -> WB.
- WB: reg_write=1; wb_src=01 for load, 00 otherwise. Next state FETCH.
- BRANCH: alu_src_a=01, alu_src_b=1.
  - If branch_taken: pc_write=1, pc_src=1.
  - Next state FETCH.
- JUMP: reg_write=1, wb_src=10, pc_write=1, pc_src=1, alu_src_b=1.
  - alu_src_a=01 for jal, 00 for jalr.
  - Next state FETCH.
- Wait counter:
  - Clears on entry to FETCH or MEM and increments each cycle the state waits with mem_ready=0.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT: next state ERROR, error=1.
  - mem_ready in that same cycle wins; no timeout is taken.
- ERROR: all enables 0, error=1. Held until reset.
- opcode is sampled only in DECODE/EXEC/MEM/BRANCH/JUMP; the IR is stable from the cycle after ir_write.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE moves to ERROR with error=1. pc_write stays 0, so the PC is left pointing past the faulting instruction.
- Undefined: an illegal opcode is treated as a NOP. DECODE goes to FETCH with no enables asserted; error is never set by opcodes.

Test Plan:
- Reset, then addi (0010011) with mem_ready held 1 -> state_o sequence 0,1,2,3,5,1; reg_write=1 only in WB, wb_src=00; exactly 4 cycles from FETCH back to FETCH.
- lw (0000011) with mem_ready low for 3 cycles in MEM -> mem_req=1, mem_src=1, mem_we=0 for 4 cycles; then WB with wb_src=01.
- beq (1100011) with branch_taken=1, then with 0 -> pc_write=1, pc_src=1 in BRANCH for the first; pc_write=0 for the second; both return to FETCH.
- jal then jalr -> JUMP asserts reg_write=1, wb_src=10, pc_write=1, pc_src=1; alu_src_a=01 for jal, 00 for jalr.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> ERROR after 4 wait cycles, error=1 held; a reset pulse returns to IDLE with error=0.
- Opcode 1111111: with ILLEGAL_TRAP_EN -> ERROR, error=1; without -> DECODE goes to FETCH, error=0. Reset asserted mid-MEM with mem_ready=1 -> IDLE next cycle, no reg_write.
